// File: rtl/somador_pkg.sv
// Shared definitions for the adder result-to-BCD converter: default width,
// FSM state encoding and the BCD digit type.
package somador_pkg;

  localparam int N_DEFAULT = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FIN   = 2'd2
  } state_t;

  typedef logic [3:0] bcd_digit_t;

endpackage

// File: rtl/bcd_to_7seg.sv
// Active-low gfedcba decoder for one BCD digit; non-decimal codes blank.
// Present only when CONV_RES_SEVEN_SEG_EN is defined.
`ifdef CONV_RES_SEVEN_SEG_EN
module bcd_to_7seg
  import somador_pkg::*;
(
  input  bcd_digit_t digit_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = 7'b1111111;
    case (digit_i)
      4'd0: seg_o = 7'b1000000;
      4'd1: seg_o = 7'b1111001;
      4'd2: seg_o = 7'b0100100;
      4'd3: seg_o = 7'b0110000;
      4'd4: seg_o = 7'b0011001;
      4'd5: seg_o = 7'b0010010;
      4'd6: seg_o = 7'b0000010;
      4'd7: seg_o = 7'b1111000;
      4'd8: seg_o = 7'b0000000;
      4'd9: seg_o = 7'b0010000;
      default: seg_o = 7'b1111111;
    endcase
  end

endmodule
`endif

// File: rtl/conv_res_bcd.sv
// Converts the adder's (N+1)-bit 2's-complement sum to sign + two BCD digits
// by double-dabble. Optional segment outputs under CONV_RES_SEVEN_SEG_EN.
module conv_res_bcd
  import somador_pkg::*;
#(
  parameter int N = N_DEFAULT
) (
  input  logic         clk,
  input  logic         RESET,
  input  logic         start,
  input  logic [N:0]   res,
  output logic         busy,
  output logic         done,
  output logic         sign,
  output logic [3:0]   bcd_tens,
  output logic [3:0]   bcd_units
`ifdef CONV_RES_SEVEN_SEG_EN
  ,
  output logic [6:0]   seg_sign,
  output logic [6:0]   seg_tens,
  output logic [6:0]   seg_units
`endif
);

  localparam int CW = $clog2(N + 2);
  localparam logic [CW-1:0] LAST = CW'(N);

  state_t         state_q, state_d;
  logic [N:0]     mag_q, mag_d;
  logic [7:0]     scr_q, scr_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           neg_q, neg_d;
  logic           sign_q, sign_d;
  bcd_digit_t     tens_q, tens_d, units_q, units_d;
  logic [7:0]     adj;
  logic           load;

  always_comb begin
    adj = scr_q;
    if (scr_q[3:0] >= 4'd5) adj[3:0] = scr_q[3:0] + 4'd3;
    if (scr_q[7:4] >= 4'd5) adj[7:4] = scr_q[7:4] + 4'd3;

    state_d = state_q;
    mag_d   = mag_q;
    scr_d   = scr_q;
    cnt_d   = cnt_q;
    neg_d   = neg_q;
    sign_d  = sign_q;
    tens_d  = tens_q;
    units_d = units_q;
    load    = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          // Unsigned view of -res covers -2^N, which needs all N+1 bits.
          neg_d   = res[N];
          mag_d   = res[N] ? -res : res;
          scr_d   = '0;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        {scr_d, mag_d} = {adj, mag_q} << 1;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          load    = 1'b1;
          sign_d  = neg_q;
          tens_d  = scr_d[7:4];
          units_d = scr_d[3:0];
          state_d = FIN;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      state_q <= IDLE;
      mag_q   <= '0;
      scr_q   <= '0;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      sign_q  <= 1'b0;
      tens_q  <= '0;
      units_q <= '0;
    end else begin
      state_q <= state_d;
      mag_q   <= mag_d;
      scr_q   <= scr_d;
      cnt_q   <= cnt_d;
      neg_q   <= neg_d;
      sign_q  <= sign_d;
      tens_q  <= tens_d;
      units_q <= units_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign done      = (state_q == FIN);
  assign sign      = sign_q;
  assign bcd_tens  = tens_q;
  assign bcd_units = units_q;

`ifdef CONV_RES_SEVEN_SEG_EN
  logic [6:0] seg_tens_d, seg_units_d;
  logic [6:0] seg_sign_q, seg_tens_q, seg_units_q;

  bcd_to_7seg u_seg_tens  (.digit_i(tens_d),  .seg_o(seg_tens_d));
  bcd_to_7seg u_seg_units (.digit_i(units_d), .seg_o(seg_units_d));

  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      seg_sign_q  <= '1;
      seg_tens_q  <= '1;
      seg_units_q <= '1;
    end else if (load) begin
      seg_sign_q  <= sign_d ? 7'b0111111 : 7'b1111111;
      seg_tens_q  <= seg_tens_d;
      seg_units_q <= seg_units_d;
    end
  end

  assign seg_sign  = seg_sign_q;
  assign seg_tens  = seg_tens_q;
  assign seg_units = seg_units_q;
`else
  logic unused_load;
  assign unused_load = load;
`endif

endmodule

// File: tb/tb_conv_res_bcd.sv
// Directed self-checking bench for conv_res_bcd (N=5).
module tb_conv_res_bcd;

  logic       clk = 1'b0;
  logic       RESET;
  logic       start;
  logic [5:0] res;
  logic       busy, done, sign;
  logic [3:0] bcd_tens, bcd_units;
`ifdef CONV_RES_SEVEN_SEG_EN
  logic [6:0] seg_sign, seg_tens, seg_units;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  conv_res_bcd #(.N(5)) dut (
    .clk       (clk),
    .RESET     (RESET),
    .start     (start),
    .res       (res),
    .busy      (busy),
    .done      (done),
    .sign      (sign),
    .bcd_tens  (bcd_tens),
    .bcd_units (bcd_units)
`ifdef CONV_RES_SEVEN_SEG_EN
    ,
    .seg_sign  (seg_sign),
    .seg_tens  (seg_tens),
    .seg_units (seg_units)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Start at edge 0, expect done exactly at edge 6 with {s,t,u}; outputs hold prev until then.
  task automatic do_conv(input string tag, input logic [5:0] r, input logic [8:0] expv,
                         input logic [8:0] prev);
    int edge_no;
    bit seen;
    @(negedge clk); start = 1'b1; res = r;
    @(posedge clk); #1;
    chk({tag, "_busy0"}, 32'(busy), 32'd1);
    @(negedge clk); start = 1'b0;
    edge_no = 0; seen = 1'b0;
    for (int i = 1; i <= 20 && !seen; i++) begin
      @(posedge clk); #1;
      if (done) begin
        seen = 1'b1; edge_no = i;
      end else if (i == 5) begin
        chk({tag, "_hold"}, 32'({sign, bcd_tens, bcd_units}), 32'(prev));
      end
    end
    chk({tag, "_done_edge"}, 32'(edge_no), 32'd6);
    chk({tag, "_result"}, 32'({sign, bcd_tens, bcd_units}), 32'(expv));
    @(posedge clk); #1;
    chk({tag, "_idle"}, 32'({busy, done}), 32'd0);
  endtask

  initial begin
    int ndone;
    int edge_no;
    RESET = 1'b1; start = 1'b0; res = '0;
    #12;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_out", 32'({sign, bcd_tens, bcd_units}), 32'd0);
`ifdef CONV_RES_SEVEN_SEG_EN
    chk("rst_seg", 32'({seg_sign, seg_tens, seg_units}), 32'({7'h7F, 7'h7F, 7'h7F}));
`endif
    @(negedge clk); RESET = 1'b0;

    do_conv("m5", 6'b111011, {1'b1, 4'd0, 4'd5}, 9'd0);
`ifdef CONV_RES_SEVEN_SEG_EN
    chk("seg_m5", 32'({seg_sign, seg_tens, seg_units}),
        32'({7'b0111111, 7'b1000000, 7'b0010010}));
`endif
    do_conv("m32", 6'b100000, {1'b1, 4'd3, 4'd2}, {1'b1, 4'd0, 4'd5});
    do_conv("p31", 6'b011111, {1'b0, 4'd3, 4'd1}, {1'b1, 4'd3, 4'd2});
    do_conv("zero", 6'b000000, {1'b0, 4'd0, 4'd0}, {1'b0, 4'd3, 4'd1});
    do_conv("p10", 6'b001010, {1'b0, 4'd1, 4'd0}, {1'b0, 4'd0, 4'd0});

    // Re-pulsed start at edge 3 must be ignored.
    @(negedge clk); start = 1'b1; res = 6'b000111;
    @(posedge clk);
    ndone = 0; edge_no = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == 3) begin start = 1'b1; res = 6'b100000; end
      else start = 1'b0;
      @(posedge clk); #1;
      if (done) begin
        ndone++;
        if (edge_no == 0) edge_no = i;
      end
    end
    chk("ign_ndone", 32'(ndone), 32'd1);
    chk("ign_edge", 32'(edge_no), 32'd6);
    chk("ign_result", 32'({sign, bcd_tens, bcd_units}), 32'({1'b0, 4'd0, 4'd7}));

    // Reset at edge 3 abandons the conversion.
    @(negedge clk); start = 1'b1; res = 6'b111011;
    @(posedge clk);
    ndone = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (i == 3) begin
        RESET = 1'b1; #1;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        chk("mid_rst_out", 32'({sign, bcd_tens, bcd_units}), 32'd0);
      end
      if (i == 4) RESET = 1'b0;
      @(posedge clk); #1;
      if (done) ndone++;
    end
    chk("mid_rst_nodone", 32'(ndone), 32'd0);
    chk("mid_rst_idle", 32'(busy), 32'd0);
    do_conv("post_rst", 6'b100000, {1'b1, 4'd3, 4'd2}, 9'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
